// File: rtl/perf_counter_unit.sv
// Six event counters (cycles, instructions, icache/dcache requests and hits) with sticky halt freeze and handshake readout.
// Counters update every edge; readout returns rd_ack one cycle after rd_req, with rd_data holding the pre-increment value.
// No backpressure on events; rd_req is ignored while an ack is in flight. Optional build macro: PERF_SATURATE_EN (saturate instead of wrap).
`timescale 1ns/1ps
module perf_counter_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reg_write,
  input  logic             mem_write,
  input  logic             halt,
  input  logic             icache_req,
  input  logic             icache_hit,
  input  logic             dcache_req,
  input  logic             dcache_hit,
  input  logic             clear,
  input  logic             rd_req,
  input  logic [2:0]       rd_sel,
  output logic             rd_ack,
  output logic [CNT_W-1:0] rd_data,
  output logic             halted
);

  localparam int NUM_CNT = 6;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } rdState_t;

  rdState_t           state;
  rdState_t           nextState;
  logic [CNT_W-1:0]   cnt [NUM_CNT];
  logic [NUM_CNT-1:0] incEn;
  logic [CNT_W-1:0]   selVal;

  // Next value of a counter that is being bumped this edge.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef PERF_SATURATE_EN
    bump = (&v) ? v : v + CNT_W'(1);
`else
    bump = v + CNT_W'(1);
`endif
  endfunction

  // Per-counter increment enables; a hit without its request is not counted.
  always_comb begin
    incEn = '0;
    if (!halted) begin
      incEn[0] = 1'b1;
      incEn[1] = reg_write | mem_write | halt;
      incEn[2] = icache_req;
      incEn[3] = icache_req & icache_hit;
      incEn[4] = dcache_req;
      incEn[5] = dcache_req & dcache_hit;
    end
  end

  // Counter bank: clear beats every increment, halted freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (incEn[i]) cnt[i] <= bump(cnt[i]);
      end
    end
  end

  // Sticky halt flag; the halt cycle itself is still counted above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted <= 1'b0;
    end else if (clear) begin
      halted <= 1'b0;
    end else if (halt) begin
      halted <= 1'b1;
    end
  end

  // Readout mux; unused selects return zero.
  always_comb begin
    selVal = '0;
    case (rd_sel)
      3'd0: selVal = cnt[0];
      3'd1: selVal = cnt[1];
      3'd2: selVal = cnt[2];
      3'd3: selVal = cnt[3];
      3'd4: selVal = cnt[4];
      3'd5: selVal = cnt[5];
      default: selVal = '0;
    endcase
  end

  // Readout FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Readout FSM next state: one ack cycle per accepted request.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (rd_req) nextState = ACK;
      ACK:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign rd_ack = (state == ACK);

  // Capture the pre-increment (and pre-clear) value on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (state == IDLE && rd_req) begin
      rd_data <= selVal;
    end
  end

endmodule

// File: tb/tb_perf_counter_unit.sv
`timescale 1ns/1ps
module tb_perf_counter_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_write, mem_write, halt;
  logic        icache_req, icache_hit, dcache_req, dcache_hit;
  logic        clear, rd_req;
  logic [2:0]  rd_sel;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic        halted;
  logic        rd_ack4;
  logic [3:0]  rd_data4;
  logic        halted4;

  int checks = 0;
  int errors = 0;
  logic [31:0] expQ[$];

`ifdef PERF_SATURATE_EN
  localparam logic [31:0] EXP_SMALL = 32'd15;
`else
  localparam logic [31:0] EXP_SMALL = 32'd4;
`endif

  always #5 clk = ~clk;

  perf_counter_unit #(.CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .mem_write(mem_write), .halt(halt),
    .icache_req(icache_req), .icache_hit(icache_hit), .dcache_req(dcache_req), .dcache_hit(dcache_hit),
    .clear(clear), .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(rd_ack), .rd_data(rd_data), .halted(halted)
  );

  perf_counter_unit #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .mem_write(mem_write), .halt(halt),
    .icache_req(icache_req), .icache_hit(icache_hit), .dcache_req(dcache_req), .dcache_hit(dcache_hit),
    .clear(clear), .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(rd_ack4), .rd_data(rd_data4), .halted(halted4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doClear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic readCnt(input logic [2:0] sel, input logic [31:0] exp);
    rd_sel = sel;
    rd_req = 1'b1;
    expQ.push_back(exp);
    tick();
    rd_req = 1'b0;
    tick();
  endtask

  // Monitor: every ack pops one expected readout value.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_ack === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack with rd_data %0d required no ack", rd_data);
        end else begin
          check("rd_data", rd_data, expQ.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    {reg_write, mem_write, halt, icache_req, icache_hit, dcache_req, dcache_hit, clear, rd_req} = '0;
    rd_sel = 3'd0;
    #2;
    check("reset_rd_ack", rd_ack, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_halted", halted, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // 10 register writes, then a halt, then idle: both counters read 11
    reg_write = 1'b1;
    repeat (10) tick();
    reg_write = 1'b0;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("halted_set", halted, 1);
    check("halted4_set", halted4, 1);
    repeat (5) tick();
    readCnt(3'd0, 32'd11);
    readCnt(3'd1, 32'd11);
    check("halted_sticky", halted, 1);

    // cache request/hit qualification and unused selects
    doClear();
    check("halted_cleared", halted, 0);
    icache_req = 1'b1; icache_hit = 1'b1;
    repeat (4) tick();
    icache_req = 1'b0;
    repeat (3) tick();
    icache_hit = 1'b0;
    dcache_req = 1'b1;
    repeat (2) tick();
    dcache_hit = 1'b1;
    tick();
    dcache_req = 1'b0;
    repeat (2) tick();
    dcache_hit = 1'b0;
    readCnt(3'd2, 32'd4);
    readCnt(3'd3, 32'd4);
    readCnt(3'd4, 32'd3);
    readCnt(3'd5, 32'd1);
    readCnt(3'd1, 32'd0);
    readCnt(3'd6, 32'd0);
    readCnt(3'd7, 32'd0);

    // rd_req held for 4 cycles: acks on alternate cycles, data = cycle count at capture
    doClear();
    rd_sel = 3'd0;
    rd_req = 1'b1;
    expQ.push_back(32'd0);
    tick();
    check("held_ack_1", rd_ack, 1);
    tick();
    check("held_ack_2", rd_ack, 0);
    expQ.push_back(32'd2);
    tick();
    check("held_ack_3", rd_ack, 1);
    tick();
    check("held_ack_4", rd_ack, 0);
    rd_req = 1'b0;

    // clear + halt + read + instruction increment all on one edge
    doClear();
    reg_write = 1'b1;
    repeat (3) tick();
    clear = 1'b1; halt = 1'b1;
    rd_sel = 3'd1; rd_req = 1'b1;
    expQ.push_back(32'd3);
    tick();
    clear = 1'b0; halt = 1'b0; rd_req = 1'b0; reg_write = 1'b0;
    check("clear_beats_halt", halted, 0);
    tick();
    readCnt(3'd1, 32'd0);
    readCnt(3'd0, 32'd3);

    // narrow counters: 20 cycles either wrap to 4 or saturate at 15
    doClear();
    repeat (20) tick();
    rd_sel = 3'd0; rd_req = 1'b1;
    expQ.push_back(32'd20);
    tick();
    rd_req = 1'b0;
    check("small_ack", rd_ack4, 1);
    check("small_cycles", {28'd0, rd_data4}, EXP_SMALL);
    tick();

    // reset during ACK: ack and data drop at once, no ack afterwards
    doClear();
    rd_sel = 3'd0; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("ack_before_rst", rd_ack, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ack", rd_ack, 0);
    check("rst_mid_data", rd_data, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_ack_after_rst", rd_ack, 0);
    end
    readCnt(3'd0, 32'd3);

    tick();
    check("queue_empty", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
